watchdog_feeder: RTL and testbench

- Feeding side of the clock's watchdog. Collects per-client liveness strobes and drives the watchdog sense bus with a Gray-coded pattern.
- The pattern advances only while every client proves itself alive within each feed window.
- On a watchdog bark, emits a stretched system-reset pulse, counts the event, then runs a grace period before resuming supervised feeding.

---
 rtl/watchdog_pkg.sv | 18 +
 rtl/gray_counter.sv | 33 +++
 rtl/watchdog_feeder.sv | 136 +++++++++++++
 tb/tb_watchdog_feeder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// Shared definitions for the clock watchdog and its feeder: default widths,
// feeder state encoding and the binary-to-Gray helper.
package watchdog_pkg;

  localparam int WDT_SENSE_WIDTH      = 4;
  localparam int WDT_BARK_COUNT_WIDTH = 4;

  typedef enum logic [1:0] {
    FEEDING,
    RECOVER,
    GRACE
  } feeder_state_t;

  function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Wrapping binary counter with a registered Gray-coded output; one output bit
// toggles per enabled cycle.
module gray_counter
  import watchdog_pkg::*;
#(
  parameter int WIDTH = WDT_SENSE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;

  always_comb begin
    bin_next  = bin + WIDTH'(1);
    gray_next = WIDTH'(bin_to_gray(32'(bin_next)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= '0;
      gray <= '0;
    end else if (enable) begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/watchdog_feeder.sv
// Feeds the watchdog with a Gray pattern while all clients stay alive; on a
// bark it stretches a system reset, counts the event and runs a grace period.
module watchdog_feeder
  import watchdog_pkg::*;
#(
  parameter int NUM_FEED_OUTPUTS = WDT_SENSE_WIDTH,
  parameter int NUM_CLIENTS      = 2,
  parameter int FEED_PERIOD      = 4,
  parameter int RESET_PULSE      = 8,
  parameter int GRACE_SLOTS      = 2,
  parameter int BARK_COUNT_WIDTH = WDT_BARK_COUNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [NUM_CLIENTS-1:0]      client_alive,
  input  logic                        bark,
  output logic [NUM_FEED_OUTPUTS-1:0] feed_out,
  output logic                        sys_reset_out,
  output logic                        starving,
  output logic [BARK_COUNT_WIDTH-1:0] bark_count
);

  localparam int PW = (FEED_PERIOD > 1) ? $clog2(FEED_PERIOD) : 1;
  localparam int CW = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
  localparam int GW = (GRACE_SLOTS > 1) ? $clog2(GRACE_SLOTS) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(FEED_PERIOD - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(RESET_PULSE - 1);
  localparam logic [GW-1:0] GRACE_LAST  = GW'((GRACE_SLOTS > 0) ? GRACE_SLOTS - 1 : 0);

  feeder_state_t          state;
  logic [PW-1:0]          period_cnt;
  logic [CW-1:0]          pulse_cnt;
  logic [GW-1:0]          grace_cnt;
  logic [NUM_CLIENTS-1:0] seen;

  logic slot;
  logic all_seen;
  logic feed_adv;

  always_comb begin
    slot     = tick && (period_cnt == PERIOD_LAST);
    // Strobes arriving in the slot cycle itself still count for the closing window.
    all_seen = &(seen | client_alive);
    feed_adv = 1'b0;
    case (state)
      FEEDING: feed_adv = bark || (slot && all_seen);
      GRACE:   feed_adv = slot;
      default: feed_adv = 1'b0;
    endcase
  end

  gray_counter #(
    .WIDTH(NUM_FEED_OUTPUTS)
  ) u_feed (
    .clk   (clk),
    .reset (reset),
    .enable(feed_adv),
    .gray  (feed_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FEEDING;
      period_cnt    <= '0;
      pulse_cnt     <= '0;
      grace_cnt     <= '0;
      seen          <= '0;
      sys_reset_out <= 1'b0;
      starving      <= 1'b0;
      bark_count    <= '0;
    end else begin
      unique case (state)
        FEEDING: begin
          if (bark) begin
            // Bark wins over a coincident slot: the single advance is the re-arm feed.
            state         <= RECOVER;
            sys_reset_out <= 1'b1;
            pulse_cnt     <= '0;
            seen          <= '0;
            period_cnt    <= '0;
            if (bark_count != '1) begin
              bark_count <= bark_count + BARK_COUNT_WIDTH'(1);
            end
          end else begin
            if (tick) begin
              period_cnt <= slot ? '0 : period_cnt + PW'(1);
            end
            if (slot) begin
              starving <= !all_seen;
              seen     <= '0;
            end else begin
              seen <= seen | client_alive;
            end
          end
        end

        RECOVER: begin
          if (pulse_cnt == PULSE_LAST) begin
            sys_reset_out <= 1'b0;
            period_cnt    <= '0;
            seen          <= '0;
            grace_cnt     <= '0;
            if (GRACE_SLOTS == 0) begin
              state <= FEEDING;
            end else begin
              state    <= GRACE;
              starving <= 1'b0;
            end
          end else begin
            pulse_cnt <= pulse_cnt + CW'(1);
          end
        end

        GRACE: begin
          seen     <= '0;
          starving <= 1'b0;
          if (tick) begin
            period_cnt <= slot ? '0 : period_cnt + PW'(1);
          end
          if (slot) begin
            if (grace_cnt == GRACE_LAST) begin
              state <= FEEDING;
            end else begin
              grace_cnt <= grace_cnt + GW'(1);
            end
          end
        end

        default: state <= FEEDING;
      endcase
    end
  end

endmodule

// File: tb/tb_watchdog_feeder.sv
// Directed scoreboard bench for watchdog_feeder: stimulus queues the expected
// outputs for each clock edge, a monitor pops and compares on the falling edge.
module tb_watchdog_feeder;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [1:0] client_alive;
  logic       bark;
  logic [3:0] feed_out;
  logic       sys_reset_out;
  logic       starving;
  logic [3:0] bark_count;

  watchdog_feeder #(
    .NUM_FEED_OUTPUTS(4),
    .NUM_CLIENTS     (2),
    .FEED_PERIOD     (4),
    .RESET_PULSE     (8),
    .GRACE_SLOTS     (2),
    .BARK_COUNT_WIDTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .client_alive (client_alive),
    .bark         (bark),
    .feed_out     (feed_out),
    .sys_reset_out(sys_reset_out),
    .starving     (starving),
    .bark_count   (bark_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         phase;
    logic [3:0] feed;
    logic       sr;
    logic       st;
    logic [3:0] bc;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  // Gray sequence for a 4-bit counter, written out by hand.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Expected state after the upcoming edge.
  int   phase = 0;
  int   fi    = 0;
  logic e_sr  = 1'b0;
  logic e_st  = 1'b0;
  int   e_bc  = 0;

  task automatic cyc(input logic t, input logic [1:0] a, input logic b, input logic r);
    exp_t e;
    tick         = t;
    client_alive = a;
    bark         = b;
    reset        = r;
    @(posedge clk);
    e.phase = phase;
    e.feed  = gtab[fi % 16];
    e.sr    = e_sr;
    e.st    = e_st;
    e.bc    = 4'(e_bc);
    sb.push_back(e);
    #1;
  endtask

  // One feed window of four ticks: three plain cycles, then the slot cycle.
  task automatic window(input logic [1:0] a_early, input logic [1:0] a_slot,
                        input logic b, input int adv, input logic st_next);
    repeat (3) cyc(1'b1, a_early, b, 1'b0);
    fi   = fi + adv;
    e_st = st_next;
    cyc(1'b1, a_slot, b, 1'b0);
  endtask

  task automatic bark_entry();
    fi   = fi + 1;
    e_sr = 1'b1;
    if (e_bc < 15) e_bc = e_bc + 1;
    cyc(1'b1, 2'b11, 1'b1, 1'b0);
  endtask

  task automatic recover_rest(input logic hold);
    repeat (7) cyc(1'b1, 2'b11, hold, 1'b0);
    e_sr = 1'b0;
    e_st = 1'b0;
    cyc(1'b1, 2'b11, hold, 1'b0);
    window(2'b00, 2'b00, hold, 1, 1'b0);
    window(2'b00, 2'b00, hold, 1, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        nvec++;
        if (feed_out !== e.feed || sys_reset_out !== e.sr ||
            starving !== e.st || bark_count !== e.bc) begin
          nmis++;
          $display("FAIL phase%0d vec%0d t=%0t got feed=%b sr=%b st=%b bc=%0d want feed=%b sr=%b st=%b bc=%0d",
                   e.phase, nvec, $time, feed_out, sys_reset_out, starving, bark_count,
                   e.feed, e.sr, e.st, e.bc);
        end
      end
    end
  end

  initial begin : stimulus
    tick = 1'b0; client_alive = 2'b00; bark = 1'b0; reset = 1'b1;

    phase = 0;
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);

    phase = 1;
    repeat (4) window(2'b11, 2'b11, 1'b0, 1, 1'b0);

    phase = 2;
    window(2'b01, 2'b01, 1'b0, 0, 1'b1);
    window(2'b01, 2'b01, 1'b0, 0, 1'b1);
    window(2'b11, 2'b11, 1'b0, 1, 1'b0);
    window(2'b01, 2'b11, 1'b0, 1, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    fi = fi + 1;
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) fi = fi + 1;
      cyc(1'(k % 2), 2'b11, 1'b0, 1'b0);
    end

    phase = 3;
    bark_entry();
    recover_rest(1'b0);

    phase = 4;
    window(2'b00, 2'b00, 1'b0, 0, 1'b1);

    phase = 5;
    repeat (3) cyc(1'b1, 2'b11, 1'b0, 1'b0);
    fi   = fi + 1;
    e_sr = 1'b1;
    e_bc = e_bc + 1;
    cyc(1'b1, 2'b11, 1'b1, 1'b0);
    recover_rest(1'b1);
    window(2'b11, 2'b11, 1'b0, 1, 1'b0);

    phase = 6;
    repeat (14) begin
      bark_entry();
      recover_rest(1'b0);
    end

    phase = 7;
    bark_entry();
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    fi = 0; e_sr = 1'b0; e_st = 1'b0; e_bc = 0;
    cyc(1'b1, 2'b11, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    window(2'b11, 2'b11, 1'b0, 1, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d expected vectors never compared, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
